// File: rtl/bcd_to_binary.sv
// Four-digit packed BCD to 13-bit binary converter.
// Multiplies-and-adds one digit per clock, MSD first, saturating at 8191.
module bcd_to_binary (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        Start,
  input  logic [15:0] Bcd,
  output logic        Busy,
  output logic        Done,
  output logic [12:0] Binary,
  output logic        InvalidDigit,
  output logic        Overflow
);

  localparam int unsigned BCD_W   = 16;
  localparam int unsigned BIN_W   = 13;
  localparam int unsigned ACC_W   = 14;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned DIG_W   = 4;
  localparam int unsigned MAX_BIN = 8191;
  localparam int unsigned MAX_DIG = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [BCD_W-1:0]   digits_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [DIG_W-1:0]   digit_c;
  logic               invalid_c;
  logic               last_c;

  // Current digit, thousands first; validity judged on the captured word only.
  always_comb begin
    digit_c = '0;
    case (cnt_q)
      2'd0:    digit_c = digits_q[15:12];
      2'd1:    digit_c = digits_q[11:8];
      2'd2:    digit_c = digits_q[7:4];
      default: digit_c = digits_q[3:0];
    endcase
    invalid_c = (digits_q[15:12] > DIG_W'(MAX_DIG)) ||
                (digits_q[11:8]  > DIG_W'(MAX_DIG)) ||
                (digits_q[7:4]   > DIG_W'(MAX_DIG)) ||
                (digits_q[3:0]   > DIG_W'(MAX_DIG));
    acc_d  = ACC_W'(acc_q * ACC_W'(10)) + ACC_W'(digit_c);
    last_c = (cnt_q == CNT_W'(3));
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q      <= IDLE;
      digits_q     <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Binary       <= '0;
      InvalidDigit <= 1'b0;
      Overflow     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (Start) begin
            digits_q <= Bcd;
            acc_q    <= '0;
            cnt_q    <= '0;
            Busy     <= 1'b1;
            state_q  <= RUN;
          end else begin
            Busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_c) begin
            state_q <= DONE;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            // Invalid beats overflow; overflow saturates.
            if (invalid_c) begin
              Binary       <= '0;
              InvalidDigit <= 1'b1;
              Overflow     <= 1'b0;
            end else if (acc_d > ACC_W'(MAX_BIN)) begin
              Binary       <= BIN_W'(MAX_BIN);
              InvalidDigit <= 1'b0;
              Overflow     <= 1'b1;
            end else begin
              Binary       <= acc_d[BIN_W-1:0];
              InvalidDigit <= 1'b0;
              Overflow     <= 1'b0;
            end
          end
        end
        default: begin
          Busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary: latency, saturation, invalid digits,
// ignored restart, back-to-back streaming and asynchronous reset abort.
module tb_bcd_to_binary;

  logic        Clock;
  logic        ResetN;
  logic        Start;
  logic [15:0] Bcd;
  logic        Busy;
  logic        Done;
  logic [12:0] Binary;
  logic        InvalidDigit;
  logic        Overflow;

  int checks;
  int errors;

  bcd_to_binary dut (
    .Clock        (Clock),
    .ResetN       (ResetN),
    .Start        (Start),
    .Bcd          (Bcd),
    .Busy         (Busy),
    .Done         (Done),
    .Binary       (Binary),
    .InvalidDigit (InvalidDigit),
    .Overflow     (Overflow)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    Start  = 1'b0;
    Bcd    = 16'h0000;
    #1;
    checks++;
    if ({Busy, Done, Binary, InvalidDigit, Overflow} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0", {Busy, Done, Binary, InvalidDigit, Overflow});
    end
    tick();
    tick();
    ResetN = 1'b1;
    tick();
    checks++;
    if ({Busy, Done, Binary, InvalidDigit, Overflow} !== 17'd0) begin
      errors++;
      $display("FAIL idle_after_reset got=%h want=0", {Busy, Done, Binary, InvalidDigit, Overflow});
    end
  endtask

  task automatic test_convert_1234();
    Start = 1'b1;
    Bcd   = 16'h1234;
    tick();
    Start = 1'b0;
    Bcd   = 16'hFFFF;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (Busy !== 1'b1 || Done !== 1'b0) begin
        errors++;
        $display("FAIL run_1234_cycle%0d busy=%b done=%b want busy=1 done=0", c, Busy, Done);
      end
      tick();
    end
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL done_1234 busy=%b done=%b want busy=0 done=1", Busy, Done);
    end
    checks++;
    if (Binary !== 13'h04D2 || InvalidDigit !== 1'b0 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL result_1234 bin=%0d inv=%b ovf=%b want 1234 0 0", Binary, InvalidDigit, Overflow);
    end
    tick();
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Binary !== 13'd1234) begin
      errors++;
      $display("FAIL after_1234 done=%b busy=%b bin=%0d want 0 0 1234", Done, Busy, Binary);
    end
  endtask

  task automatic test_boundary();
    logic [15:0] vbcd [7];
    logic [12:0] vbin [7];
    logic        vinv [7];
    logic        vovf [7];
    logic [12:0] prev;
    vbcd = '{16'h8191, 16'h8192, 16'h9999, 16'h12A4, 16'hF999, 16'h0000, 16'h0009};
    vbin = '{13'd8191, 13'd8191, 13'd8191, 13'd0,    13'd0,    13'd0,    13'd9};
    vinv = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b1,     1'b0,     1'b0};
    vovf = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b0,     1'b0,     1'b0};
    prev = 13'd1234;
    for (int i = 0; i < 7; i++) begin
      Start = 1'b1;
      Bcd   = vbcd[i];
      tick();
      Start = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if (Binary !== prev || Done !== 1'b0) begin
        errors++;
        $display("FAIL hold_%h bin=%0d done=%b want %0d 0", vbcd[i], Binary, Done, prev);
      end
      tick();
      checks++;
      if (Done !== 1'b1 || Binary !== vbin[i] || InvalidDigit !== vinv[i] || Overflow !== vovf[i]) begin
        errors++;
        $display("FAIL result_%h done=%b bin=%0d inv=%b ovf=%b want 1 %0d %b %b",
                 vbcd[i], Done, Binary, InvalidDigit, Overflow, vbin[i], vinv[i], vovf[i]);
      end
      prev = vbin[i];
      tick();
    end
  endtask

  task automatic test_ignore_restart();
    Start = 1'b1;
    Bcd   = 16'h0042;
    tick();
    Start = 1'b0;
    tick();
    Start = 1'b1;
    Bcd   = 16'h0099;
    tick();
    Start = 1'b0;
    tick();
    checks++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      errors++;
      $display("FAIL restart_run busy=%b done=%b want 1 0", Busy, Done);
    end
    tick();
    checks++;
    if (Done !== 1'b1 || Binary !== 13'd42 || InvalidDigit !== 1'b0 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL restart_result done=%b bin=%0d want 1 42", Done, Binary);
    end
    tick();
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_idle done=%b busy=%b want 0 0", Done, Busy);
    end
  endtask

  task automatic test_back_to_back();
    Start = 1'b1;
    Bcd   = 16'h0007;
    tick();
    for (int r = 0; r < 3; r++) begin
      for (int c = 1; c <= 5; c++) begin
        if (c == 5 && r == 2) Start = 1'b0;
        if (c > 1) begin
          tick();
        end else begin
          tick();
        end
        if (c < 4) begin
          checks++;
          if (Done !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_run r%0d c%0d done=%b busy=%b want 0 1", r, c, Done, Busy);
          end
        end else if (c == 4) begin
          checks++;
          if (Done !== 1'b1 || Busy !== 1'b0 || Binary !== 13'd7) begin
            errors++;
            $display("FAIL b2b_done r%0d done=%b busy=%b bin=%0d want 1 0 7", r, Done, Busy, Binary);
          end
        end else begin
          checks++;
          if (Done !== 1'b0 || Busy !== (r < 2)) begin
            errors++;
            $display("FAIL b2b_rearm r%0d done=%b busy=%b want 0 %b", r, Done, Busy, r < 2);
          end
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    Start = 1'b1;
    Bcd   = 16'h0777;
    tick();
    Start = 1'b0;
    tick();
    tick();
    ResetN = 1'b0;
    #1;
    checks++;
    if ({Busy, Done, Binary, InvalidDigit, Overflow} !== 17'd0) begin
      errors++;
      $display("FAIL abort_async got=%h want=0", {Busy, Done, Binary, InvalidDigit, Overflow});
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_nodone c%0d done=%b busy=%b want 0 0", c, Done, Busy);
      end
    end
    ResetN = 1'b1;
    tick();
    Start = 1'b1;
    Bcd   = 16'h0005;
    tick();
    Start = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (Busy !== 1'b1 || Done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_run busy=%b done=%b want 1 0", Busy, Done);
    end
    tick();
    checks++;
    if (Done !== 1'b1 || Binary !== 13'd5 || InvalidDigit !== 1'b0 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_result done=%b bin=%0d want 1 5", Done, Binary);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_convert_1234();
    test_boundary();
    test_ignore_restart();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
